// File: rtl/cb_pkg.sv
// Shared connection-block helpers: field widths, field offsets and the
// configuration-loader state encoding.
package cb_pkg;

    typedef enum logic [2:0] {IDLE, HDR, LOAD, SKIP, COMMIT} cfg_state_e;

    // Select width for a channel-side output mux: 0, both CLB output sets, far channel side.
    function automatic int sngo_w(input int chn, input int clbo);
        return $clog2(chn + 2*clbo + 1);
    endfunction

    // Select width for a CLB input mux: 0, both channel sides, the other CLB's outputs.
    function automatic int clbi_w(input int chn, input int clbo);
        return $clog2(clbo + 2*chn + 1);
    endfunction

    function automatic int cfg_bits(input int chn, input int clbi_n, input int clbo);
        return 2*chn*sngo_w(chn, clbo) + 2*clbi_n*clbi_w(chn, clbo);
    endfunction

    function automatic int off_s0();
        return 0;
    endfunction

    function automatic int off_s1(input int chn, input int clbo);
        return chn*sngo_w(chn, clbo);
    endfunction

    function automatic int off_c0(input int chn, input int clbo);
        return 2*chn*sngo_w(chn, clbo);
    endfunction

    function automatic int off_c1(input int chn, input int clbi_n, input int clbo);
        return off_c0(chn, clbo) + clbi_n*clbi_w(chn, clbo);
    endfunction

endpackage

// File: rtl/MUXN.sv
// Generic N-input, 1-bit mux; a select at or beyond N yields 0.
module MUXN #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  in,
    input  logic [SW-1:0] sel,
    output logic          out
);

    always_comb begin
        out = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) out = in[i];
        end
    end

endmodule

// File: rtl/cb_cfg_loader.sv
// Serial configuration loader: ID-addressed frames into a shadow register,
// atomic commit to the active register. Optional parity via CB_CFG_PARITY_EN.
module cb_cfg_loader
    import cb_pkg::*;
#(
    parameter int ID_WIDTH   = 3,
    parameter int ID         = 7,
    parameter int FRAME_BITS = 280,
    parameter int CFG_BITS   = 280
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_in_start,
    input  logic                cfg_bit_in,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic                cfg_valid,
    output logic                cfg_err,
    output logic [CFG_BITS-1:0] cfg
);

    localparam int CNT_MAX = (ID_WIDTH > FRAME_BITS) ? ID_WIDTH : FRAME_BITS;
    localparam int CW      = $clog2(CNT_MAX + 1);
`ifdef CB_CFG_PARITY_EN
    localparam int FRAME_LEN = FRAME_BITS + 1;
`else
    localparam int FRAME_LEN = FRAME_BITS;
`endif
    // The first header bit is taken in IDLE, so HDR sees ID_WIDTH-1 more.
    localparam logic [CW-1:0] HDR_LAST  = CW'(ID_WIDTH - 2);
    localparam logic [CW-1:0] DATA_LAST = CW'(FRAME_LEN - 1);

    cfg_state_e            state, state_nx;
    logic [CW-1:0]         cnt;
    logic [ID_WIDTH-2:0]   hdr;
    logic [ID_WIDTH-1:0]   hdr_full;
    logic [CFG_BITS-1:0]   shadow, active;
    logic                  valid, fwd_start, fwd_bit;
    logic                  par_ok;

    assign hdr_full = {hdr, cfg_bit_in};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (cfg_in_start) state_nx = HDR;
            HDR: begin
                if (cfg_in_start)          state_nx = HDR;
                else if (cnt == HDR_LAST)  state_nx = (hdr_full == ID_WIDTH'(ID)) ? LOAD : SKIP;
            end
            LOAD: begin
                if (cfg_in_start)          state_nx = HDR;
                else if (cnt == DATA_LAST) state_nx = par_ok ? COMMIT : IDLE;
            end
            SKIP: begin
                if (cfg_in_start)          state_nx = HDR;
                else if (cnt == DATA_LAST) state_nx = IDLE;
            end
            COMMIT: state_nx = cfg_in_start ? HDR : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hdr       <= '0;
            shadow    <= '0;
            active    <= '0;
            valid     <= 1'b0;
            fwd_start <= 1'b0;
            fwd_bit   <= 1'b0;
        end else begin
            state     <= state_nx;
            fwd_start <= cfg_in_start;
            fwd_bit   <= cfg_bit_in;
            if (cfg_in_start || state_nx != state || state_nx == IDLE) cnt <= '0;
            else                                                        cnt <= cnt + CW'(1);
            if (cfg_in_start || state == HDR) hdr <= hdr_full[ID_WIDTH-2:0];
            // Shift-in lands data bit k at shadow[k] once CFG_BITS bits have arrived.
            if (cfg_in_start)
                shadow <= '0;
            else if (state == LOAD && cnt < CW'(CFG_BITS))
                shadow <= {cfg_bit_in, shadow[CFG_BITS-1:1]};
            if (state == COMMIT) begin
                active <= shadow;
                valid  <= 1'b1;
            end
        end
    end

`ifdef CB_CFG_PARITY_EN
    logic par, err;

    // At the last LOAD bit cfg_bit_in is the even-parity bit.
    assign par_ok = (par == cfg_bit_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
            err <= 1'b0;
        end else begin
            if (state != LOAD || cfg_in_start)    par <= 1'b0;
            else if (cnt < CW'(FRAME_BITS))       par <= par ^ cfg_bit_in;
            if (state == LOAD && !cfg_in_start && cnt == DATA_LAST && !par_ok) err <= 1'b1;
        end
    end

    assign cfg_err = err;
`else
    assign par_ok  = 1'b1;
    assign cfg_err = 1'b0;
`endif

    assign cfg           = active;
    assign cfg_valid     = valid;
    assign cfg_out_start = fwd_start;
    assign cfg_bit_out   = fwd_bit;

endmodule

// File: rtl/cb_cfg.sv
// Connection block with embedded serial config loader; routing is a bank of
// MUXN selectors driven from the committed config. Parity: CB_CFG_PARITY_EN.
module cb_cfg
    import cb_pkg::*;
#(
    parameter int CLB_IWIDTH = 10,
    parameter int CLB_OWIDTH = 4,
    parameter int CHN_WIDTH  = 16,
    parameter int ID_WIDTH   = 3,
    parameter int ID         = 7,
    parameter int FRAME_BITS = 280
) (
    input  logic                  clk,
    input  logic                  crst,
    input  logic [CLB_OWIDTH-1:0] clb0_output,
    input  logic [CLB_OWIDTH-1:0] clb1_output,
    output logic [CLB_IWIDTH-1:0] clb0_input,
    output logic [CLB_IWIDTH-1:0] clb1_input,
    input  logic [CHN_WIDTH-1:0]  single0_in,
    input  logic [CHN_WIDTH-1:0]  single1_in,
    output logic [CHN_WIDTH-1:0]  single0_out,
    output logic [CHN_WIDTH-1:0]  single1_out,
    input  logic                  cfg_in_start,
    input  logic                  cfg_bit_in,
    output logic                  cfg_out_start,
    output logic                  cfg_bit_out,
    output logic                  cfg_valid,
    output logic                  cfg_err
);

    localparam int SNGO     = sngo_w(CHN_WIDTH, CLB_OWIDTH);
    localparam int CLBI     = clbi_w(CHN_WIDTH, CLB_OWIDTH);
    localparam int CFG_BITS = cfg_bits(CHN_WIDTH, CLB_IWIDTH, CLB_OWIDTH);
    localparam int OFF_S0   = off_s0();
    localparam int OFF_S1   = off_s1(CHN_WIDTH, CLB_OWIDTH);
    localparam int OFF_C0   = off_c0(CHN_WIDTH, CLB_OWIDTH);
    localparam int OFF_C1   = off_c1(CHN_WIDTH, CLB_IWIDTH, CLB_OWIDTH);
    localparam int N_SNG    = CHN_WIDTH + 2*CLB_OWIDTH + 1;
    localparam int N_CLB    = CLB_OWIDTH + 2*CHN_WIDTH + 1;

    logic [CFG_BITS-1:0] cfg;
    logic [N_SNG-1:0]    s0_src, s1_src;
    logic [N_CLB-1:0]    c0_src, c1_src;

    // Source index 0 is a constant 0 so an unconfigured pin stays quiet.
    assign s0_src = {single1_in, clb1_output, clb0_output, 1'b0};
    assign s1_src = {single0_in, clb1_output, clb0_output, 1'b0};
    assign c0_src = {clb1_output, single1_in, single0_in, 1'b0};
    assign c1_src = {clb0_output, single1_in, single0_in, 1'b0};

    cb_cfg_loader #(
        .ID_WIDTH   (ID_WIDTH),
        .ID         (ID),
        .FRAME_BITS (FRAME_BITS),
        .CFG_BITS   (CFG_BITS)
    ) u_loader (
        .clk           (clk),
        .rst           (crst),
        .cfg_in_start  (cfg_in_start),
        .cfg_bit_in    (cfg_bit_in),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .cfg_valid     (cfg_valid),
        .cfg_err       (cfg_err),
        .cfg           (cfg)
    );

    for (genvar i = 0; i < CHN_WIDTH; i++) begin : g_sng
        MUXN #(.N(N_SNG), .SW(SNGO)) u_s0 (
            .in  (s0_src),
            .sel (cfg[OFF_S0 + i*SNGO +: SNGO]),
            .out (single0_out[i])
        );
        MUXN #(.N(N_SNG), .SW(SNGO)) u_s1 (
            .in  (s1_src),
            .sel (cfg[OFF_S1 + i*SNGO +: SNGO]),
            .out (single1_out[i])
        );
    end

    for (genvar i = 0; i < CLB_IWIDTH; i++) begin : g_clb
        MUXN #(.N(N_CLB), .SW(CLBI)) u_c0 (
            .in  (c0_src),
            .sel (cfg[OFF_C0 + i*CLBI +: CLBI]),
            .out (clb0_input[i])
        );
        MUXN #(.N(N_CLB), .SW(CLBI)) u_c1 (
            .in  (c1_src),
            .sel (cfg[OFF_C1 + i*CLBI +: CLBI]),
            .out (clb1_input[i])
        );
    end

endmodule

// File: tb/tb_cb_cfg.sv
// Scoreboard bench for cb_cfg at default parameters: chain forwarding and
// routing expectations are queued as stimulus is applied and popped on check.
module tb_cb_cfg;

    localparam int CFGB   = 280;
    localparam int FRAME  = 280;
    localparam int OFF_S1 = 80;
    localparam int OFF_C0 = 160;
    localparam int OFF_C1 = 220;

    logic        clk = 1'b0;
    logic        crst;
    logic [3:0]  clb0_output, clb1_output;
    logic [9:0]  clb0_input, clb1_input;
    logic [15:0] single0_in, single1_in, single0_out, single1_out;
    logic        cfg_in_start, cfg_bit_in, cfg_out_start, cfg_bit_out, cfg_valid, cfg_err;

    cb_cfg dut (
        .clk(clk), .crst(crst),
        .clb0_output(clb0_output), .clb1_output(clb1_output),
        .clb0_input(clb0_input), .clb1_input(clb1_input),
        .single0_in(single0_in), .single1_in(single1_in),
        .single0_out(single0_out), .single1_out(single1_out),
        .cfg_in_start(cfg_in_start), .cfg_bit_in(cfg_bit_in),
        .cfg_out_start(cfg_out_start), .cfg_bit_out(cfg_bit_out),
        .cfg_valid(cfg_valid), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [9:0]  c0;
        logic [9:0]  c1;
    } route_t;

    route_t          rq[$];
    logic [1:0]      fq[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [CFGB-1:0] m_active;
    logic            m_valid, m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fld(input logic [CFGB-1:0] a, input int off, input int w);
        int v = 0;
        for (int j = 0; j < w; j++) if (a[off+j]) v |= (1 << j);
        return v;
    endfunction

    function automatic logic pick_sng(input int sel, input logic [3:0] c0o, input logic [3:0] c1o,
                                      input logic [15:0] far);
        if (sel >= 1 && sel <= 4)  return c0o[sel-1];
        if (sel >= 5 && sel <= 8)  return c1o[sel-5];
        if (sel >= 9 && sel <= 24) return far[sel-9];
        return 1'b0;
    endfunction

    function automatic logic pick_clb(input int sel, input logic [15:0] s0i, input logic [15:0] s1i,
                                      input logic [3:0] other);
        if (sel >= 1 && sel <= 16)  return s0i[sel-1];
        if (sel >= 17 && sel <= 32) return s1i[sel-17];
        if (sel >= 33 && sel <= 36) return other[sel-33];
        return 1'b0;
    endfunction

    function automatic route_t model_route(input logic [CFGB-1:0] a, input logic [3:0] c0o,
                                           input logic [3:0] c1o, input logic [15:0] s0i,
                                           input logic [15:0] s1i);
        route_t r = '0;
        for (int i = 0; i < 16; i++) begin
            r.s0[i] = pick_sng(fld(a, i*5, 5), c0o, c1o, s1i);
            r.s1[i] = pick_sng(fld(a, OFF_S1 + i*5, 5), c0o, c1o, s0i);
        end
        for (int i = 0; i < 10; i++) begin
            r.c0[i] = pick_clb(fld(a, OFF_C0 + i*6, 6), s0i, s1i, c1o);
            r.c1[i] = pick_clb(fld(a, OFF_C1 + i*6, 6), s0i, s1i, c0o);
        end
        return r;
    endfunction

    function automatic logic [CFGB-1:0] put(input logic [CFGB-1:0] d, input int off, input int w,
                                            input int v);
        for (int j = 0; j < w; j++) d[off+j] = v[j];
        return d;
    endfunction

    function automatic logic [CFGB-1:0] rand_cfg();
        logic [CFGB-1:0] d;
        for (int k = 0; k < CFGB; k++) d[k] = 1'($urandom);
        return d;
    endfunction

    // One cycle of chain traffic: check last cycle's forwarded pair, then drive.
    task automatic step(input logic st, input logic b);
        logic [1:0] e;
        @(negedge clk);
        if (fq.size() > 0) begin
            e = fq.pop_front();
            chk("fwd_start", cfg_out_start, e[1]);
            chk("fwd_bit", cfg_bit_out, e[0]);
        end
        cfg_in_start = st;
        cfg_bit_in   = b;
        fq.push_back({st, b});
    endtask

    task automatic probe_with(input logic [3:0] c0o, input logic [3:0] c1o,
                              input logic [15:0] s0i, input logic [15:0] s1i);
        route_t e;
        clb0_output = c0o; clb1_output = c1o; single0_in = s0i; single1_in = s1i;
        rq.push_back(model_route(m_active, c0o, c1o, s0i, s1i));
        #1;
        e = rq.pop_front();
        chk("single0_out", single0_out, e.s0);
        chk("single1_out", single1_out, e.s1);
        chk("clb0_input", clb0_input, e.c0);
        chk("clb1_input", clb1_input, e.c1);
    endtask

    task automatic probe_rand();
        probe_with(4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // stop_at >= 0 truncates the frame after that many data bits.
    task automatic send_frame(input logic [2:0] id, input logic [FRAME-1:0] d,
                              input bit bad_par, input int stop_at);
        for (int i = 0; i < 3; i++) step(i == 0, id[2-i]);
        for (int k = 0; k < FRAME; k++) begin
            if (k == stop_at) return;
            step(1'b0, d[k]);
        end
`ifdef CB_CFG_PARITY_EN
        step(1'b0, (^d) ^ bad_par);
`endif
    endtask

    // Old routing one cycle after the last bit, new routing the cycle after.
    task automatic finish_frame(input logic [CFGB-1:0] d, input bit commits, input bit err_exp);
        step(1'b0, 1'b0);
        chk("valid_pre", cfg_valid, m_valid);
        probe_rand();
        step(1'b0, 1'b0);
        if (commits) begin
            m_active = d;
            m_valid  = 1'b1;
        end
        if (err_exp) m_err = 1'b1;
        chk("valid", cfg_valid, m_valid);
        chk("err", cfg_err, m_err);
        probe_rand();
        probe_rand();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CFGB-1:0] d, r;
        crst = 1'b1;
        cfg_in_start = 1'b0; cfg_bit_in = 1'b0;
        clb0_output = '0; clb1_output = '0; single0_in = '0; single1_in = '0;
        m_active = '0; m_valid = 1'b0; m_err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_start", cfg_out_start, 1'b0);
        chk("rst_bit_out", cfg_bit_out, 1'b0);
        chk("rst_valid", cfg_valid, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        probe_with(4'hF, 4'hF, 16'hFFFF, 16'hFFFF);
        crst = 1'b0;
        repeat (4) step(1'b0, 1'b0);
        probe_rand();

        // single0_out[0] <- clb0_output[0]
        d = '0;
        d = put(d, 0, 5, 1);
        send_frame(3'd7, d, 1'b0, -1);
        finish_frame(d, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        probe_with(4'b0000, 4'hF, 16'hFFFF, 16'hFFFF);
        probe_with(4'b0001, 4'hF, 16'hFFFF, 16'hFFFF);
        probe_with(4'b0000, 4'hF, 16'hFFFF, 16'hFFFF);

        // Foreign header: routing unchanged
        r = rand_cfg();
        send_frame(3'b010, r, 1'b0, -1);
        finish_frame(r, 1'b0, 1'b0);

        // Random full config
        r = rand_cfg();
        send_frame(3'd7, r, 1'b0, -1);
        finish_frame(r, 1'b1, 1'b0);
        repeat (3) begin step(1'b0, 1'b0); probe_rand(); end

        // Abort at data bit 100, then a frame with an out-of-range select
        r = rand_cfg();
        send_frame(3'd7, r, 1'b0, 100);
        d = rand_cfg();
        d = put(d, OFF_C1 + 9*6, 6, 37);
        send_frame(3'd7, d, 1'b0, -1);
        finish_frame(d, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        probe_with(4'hF, 4'hF, 16'hFFFF, 16'hFFFF);
        chk("clb1_input9_oor", clb1_input[9], 1'b0);

        // Reset mid-LOAD
        r = rand_cfg();
        send_frame(3'd7, r, 1'b0, 50);
        crst = 1'b1;
        cfg_in_start = 1'b0; cfg_bit_in = 1'b0;
        fq.delete();
        fq.push_back(2'b00);
        m_active = '0; m_valid = 1'b0; m_err = 1'b0;
        #1;
        chk("midrst_valid", cfg_valid, 1'b0);
        chk("midrst_out_start", cfg_out_start, 1'b0);
        chk("midrst_bit_out", cfg_bit_out, 1'b0);
        probe_with(4'hF, 4'hF, 16'hFFFF, 16'hFFFF);
        step(1'b0, 1'b0);
        crst = 1'b0;
        step(1'b0, 1'b0);
        r = rand_cfg();
        send_frame(3'd7, r, 1'b0, -1);
        finish_frame(r, 1'b1, 1'b0);

        // Back-to-back: second start lands in the COMMIT cycle
        r = rand_cfg();
        send_frame(3'd7, r, 1'b0, -1);
        m_active = r;
        d = rand_cfg();
        send_frame(3'd7, d, 1'b0, -1);
        finish_frame(d, 1'b1, 1'b0);

`ifdef CB_CFG_PARITY_EN
        // Bad parity: no commit, sticky error; next good frame commits
        r = rand_cfg();
        send_frame(3'd7, r, 1'b1, -1);
        finish_frame(r, 1'b0, 1'b1);
        r = rand_cfg();
        send_frame(3'd7, r, 1'b0, -1);
        finish_frame(r, 1'b1, 1'b0);
        chk("err_sticky", cfg_err, 1'b1);
`endif

        repeat (2) step(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cb_cfg.md
Name: cb_cfg

Overview:
- Parametrised connection block that routes between two CLB pin sets and two single-length channel segments through per-pin muxes.
- Unlike the bare cb, it embeds its own serial configuration loader. The loader is a daisy-chained bit-serial port with an ID-addressed frame, a shadow register and an atomic commit.
- Routing never sees a partially loaded configuration.
- The block sits in each fabric tile between the switch box and the CLB.

Parameters:
- CLB_IWIDTH, 10, CLB input pins per CLB
- CLB_OWIDTH, 4, CLB output pins per CLB
- CHN_WIDTH, 16, single-length tracks per channel side
- ID_WIDTH, 3, width of block address in frame header
- ID, 7, this block's address
- FRAME_BITS, 280, data bits per frame on the chain; must be >= CFG_BITS

Ports:
- clk  in  1  fabric/config clock
- crst  in  1  asynchronous active-high reset
- clb0_output  in  CLB_OWIDTH  same-tile CLB outputs
- clb1_output  in  CLB_OWIDTH  adjacent-tile CLB outputs
- clb0_input  out  CLB_IWIDTH  same-tile CLB inputs
- clb1_input  out  CLB_IWIDTH  adjacent-tile CLB inputs
- single0_in  in  CHN_WIDTH  channel side 0 inbound
- single1_in  in  CHN_WIDTH  channel side 1 inbound
- single0_out  out  CHN_WIDTH  channel side 0 outbound
- single1_out  out  CHN_WIDTH  channel side 1 outbound
- cfg_in_start  in  1  frame-start strobe, coincident with first header bit
- cfg_bit_in  in  1  serial config data
- cfg_out_start  out  1  cfg_in_start delayed 1 cycle
- cfg_bit_out  out  1  cfg_bit_in delayed 1 cycle
- cfg_valid  out  1  high once any configuration has been committed
- cfg_err  out  1  sticky frame error (see Optional Feature)

Behaviour:

Field sizes:
- SNGO = clog2(CHN_WIDTH+2*CLB_OWIDTH+1)
- CLBI = clog2(CLB_OWIDTH+2*CHN_WIDTH+1)
- CFG_BITS = 2*CHN_WIDTH*SNGO + 2*CLB_IWIDTH*CLBI; this is 280 at defaults.

Field layout (LSB first):
- single0_out selects
- single1_out selects
- clb0_input selects
- clb1_input selects

Mux sources:
- single0_out[i]: {single1_in, clb1_output, clb0_output, 0}
- single1_out[i]: {single0_in, clb1_output, clb0_output, 0}
- clb0_input[i]: {clb1_output, single1_in, single0_in, 0}
- clb1_input[i]: {clb0_output, single1_in, single0_in, 0}
- sel=0 drives 0. A sel at or above the mux input count drives 0.
- Routing is purely combinational from the active register.

Chain forwarding:
- cfg_bit_out and cfg_out_start are registered copies of the inputs, always forwarded regardless of ID.
- Reset value of both is 0.

FSM states: IDLE, HDR, LOAD, SKIP, COMMIT.
- IDLE: on cfg_in_start go to HDR. The first header bit is captured in that same cycle.
- HDR: capture ID_WIDTH bits, MSB first.
  - If the header equals ID, go to LOAD.
  - Otherwise go to SKIP.
- LOAD: shift FRAME_BITS bits into the shadow register. Data bit k of the frame lands in shadow[k]. Bits k >= CFG_BITS are discarded.
  - After the last bit go to COMMIT.
- SKIP: count FRAME_BITS bits, then go to IDLE. The active register is untouched.
- COMMIT: one cycle. Copy shadow to active, set cfg_valid=1, return to IDLE.
  - New routing is visible the cycle after the last data bit is sampled, plus one.

Boundary rules:
- cfg_in_start in any non-IDLE state aborts the current frame and restarts HDR with this bit. The shadow is discarded and the active register is retained.
- Back-to-back frames are allowed: cfg_in_start may arrive in the COMMIT cycle. Commit still completes and HDR starts.
- Counter width is clog2(max(ID_WIDTH, FRAME_BITS)+1). The counter resets to 0 on every state entry.

Reset (crst, asynchronous):
- FSM goes to IDLE.
- Shadow and active registers are cleared to 0, so all routed outputs are 0.
- cfg_valid=0 and cfg_err=0.
- Reset mid-frame abandons the frame entirely.

Optional Feature:
CB_CFG_PARITY_EN
- Defined:
  - Each frame carries one extra bit after the FRAME_BITS data bits. This applies to both LOAD and SKIP counts.
  - The extra bit is even parity over the FRAME_BITS data bits.
  - If parity mismatches in LOAD, COMMIT is skipped, the active register is unchanged, and cfg_err is set sticky until crst.
- Undefined: no parity bit in the frame, and cfg_err is tied 0.

Decomposition:
- Shared package cb_pkg holds:
  - the clog2-based SNGO/CLBI/CFG_BITS functions and field offset functions;
  - the FSM state enum, so sb and cfg blocks use the same encoding.
- One natural sub-module: cb_cfg_loader. It holds the FSM, counter, shadow/active registers and chain forwarding, and outputs the active cfg bus.
- The routing fabric reuses MUXN inside generate loops in cb_cfg.

Test Plan:
- Reset then idle: all *_out/*_input read 0, cfg_valid=0, cfg_out_start=cfg_bit_out=0.
- Frame with ID=7 and the single0_out[0] field = 1: cfg_valid rises at COMMIT+1. single0_out[0] follows clb0_output[0] (toggled 0→1→0), and other outputs stay 0.
- Frame with header 3'b010: no change to routing. cfg_out_start/cfg_bit_out reproduce the input stream delayed exactly 1 cycle.
- Abort: a second cfg_in_start at LOAD bit 100, then a full valid frame with clb1_input[9] sel=37 (out of range). The old config is held until the new commit, then clb1_input[9]=0.
- Reset asserted mid-LOAD after a prior commit: outputs go to 0 immediately and cfg_valid=0. A following full frame commits normally.
- With CB_CFG_PARITY_EN: a frame with a wrong parity bit leaves routing unchanged and sets cfg_err=1. The next good frame commits while cfg_err stays 1.
